// File: rtl/collision_detector.sv
// Frog-vs-car collision detector: on each frame tick, snapshots positions, checks one car per cycle,
// then counts at most one hit per scan subject to a post-hit cooldown and the remaining lives.
module collision_detector #(
    parameter int TILE_SIZE      = 32,
    parameter int CAR_ROW_0      = 1,
    parameter int CAR_ROW_1      = 2,
    parameter int CAR_ROW_2      = 3,
    parameter int CAR_ROW_3      = 4,
    parameter int CAR_ROW_4      = 6,
    parameter int CAR_ROW_5      = 7,
    parameter int C_START_LIVES  = 3,
    parameter int C_HIT_COOLDOWN = 60
) (
    input  logic       i_Clk,
    input  logic       i_Rst_L,
    input  logic       i_Frame_Tick,
    input  logic       i_Restart,
    input  logic [9:0] i_Car_X_0,
    input  logic [9:0] i_Car_X_1,
    input  logic [9:0] i_Car_X_2,
    input  logic [9:0] i_Car_X_3,
    input  logic [9:0] i_Car_X_4,
    input  logic [9:0] i_Car_X_5,
    input  logic [9:0] i_Frog_X,
    input  logic [3:0] i_Frog_Row,
    output logic       o_Busy,
    output logic       o_Collision,
    output logic [2:0] o_Hit_Index,
    output logic [1:0] o_Lives,
    output logic       o_Game_Over
);

    localparam int CD_W = (C_HIT_COOLDOWN < 2) ? 1 : $clog2(C_HIT_COOLDOWN + 1);
    localparam logic [CD_W-1:0] CD_LOAD     = CD_W'(C_HIT_COOLDOWN);
    localparam logic [CD_W-1:0] CD_ONE      = CD_W'(1);
    localparam logic [1:0]      START_LIVES = 2'(C_START_LIVES);
    localparam logic [10:0]     TILE        = 11'(TILE_SIZE);
    localparam logic [2:0]      LAST_CAR    = 3'd5;

    localparam logic [3:0] CAR_ROW [6] = '{4'(CAR_ROW_0), 4'(CAR_ROW_1), 4'(CAR_ROW_2),
                                           4'(CAR_ROW_3), 4'(CAR_ROW_4), 4'(CAR_ROW_5)};

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SCAN   = 2'd1,
        REPORT = 2'd2
    } state_e;

    state_e            state_q, state_d;
    logic [2:0]        idx_q, idx_d;
    logic              hit_q, hit_d;
    logic [2:0]        hit_idx_q, hit_idx_d;
    logic [2:0]        out_idx_q, out_idx_d;
    logic [1:0]        lives_q, lives_d;
    logic [CD_W-1:0]   cooldown_q, cooldown_d;
    logic              collision_q, collision_d;
    logic              busy_q, busy_d;
    logic              load_snap;

    logic [9:0]        car_x_q [6];
    logic [9:0]        frog_x_q;
    logic [3:0]        frog_row_q;

    logic [9:0]        cur_car_x;
    logic              hit_now;

    // Both sums are 11 bits so a square near the right screen edge never wraps to X=0.
    always_comb begin
        cur_car_x = car_x_q[idx_q];
        hit_now   = (CAR_ROW[idx_q] == frog_row_q)
                 && ({1'b0, cur_car_x} < ({1'b0, frog_x_q} + TILE))
                 && ({1'b0, frog_x_q} < ({1'b0, cur_car_x} + TILE));
    end

    always_comb begin
        // NOTE: every signal gets a default here so no path leaves it unassigned, which would infer a latch.
        state_d     = state_q;
        idx_d       = idx_q;
        hit_d       = hit_q;
        hit_idx_d   = hit_idx_q;
        out_idx_d   = out_idx_q;
        lives_d     = lives_q;
        cooldown_d  = cooldown_q;
        collision_d = 1'b0;
        load_snap   = 1'b0;

        if (i_Restart) begin
            lives_d    = START_LIVES;
            cooldown_d = '0;
            state_d    = IDLE;
        end else begin
            case (state_q)
                IDLE: begin
                    if (i_Frame_Tick) begin
                        load_snap = 1'b1;
                        hit_d     = 1'b0;
                        idx_d     = 3'd0;
                        state_d   = SCAN;
                    end
                end
                SCAN: begin
                    if (hit_now && !hit_q) begin
                        hit_d     = 1'b1;
                        hit_idx_d = idx_q;
                    end
                    if (idx_q == LAST_CAR) begin
                        state_d = REPORT;
                    end else begin
                        idx_d = idx_q + 3'd1;
                    end
                end
                REPORT: begin
                    state_d = IDLE;
                    if (hit_q && (cooldown_q == '0) && (lives_q != 2'd0)) begin
                        collision_d = 1'b1;
                        out_idx_d   = hit_idx_q;
                        lives_d     = lives_q - 2'd1;
                        cooldown_d  = CD_LOAD;
                    end else if (cooldown_q != '0) begin
                        cooldown_d = cooldown_q - CD_ONE;
                    end
                end
                default: state_d = IDLE;
            endcase
        end

        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge i_Clk or negedge i_Rst_L) begin
        if (!i_Rst_L) begin
            state_q     <= IDLE;
            idx_q       <= 3'd0;
            hit_q       <= 1'b0;
            hit_idx_q   <= 3'd0;
            out_idx_q   <= 3'd0;
            lives_q     <= START_LIVES;
            cooldown_q  <= '0;
            collision_q <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            idx_q       <= idx_d;
            hit_q       <= hit_d;
            hit_idx_q   <= hit_idx_d;
            out_idx_q   <= out_idx_d;
            lives_q     <= lives_d;
            cooldown_q  <= cooldown_d;
            collision_q <= collision_d;
            busy_q      <= busy_d;
        end
    end

    // NOTE: the snapshot is only read in SCAN after being loaded on the tick, so it needs no reset.
    always_ff @(posedge i_Clk) begin
        if (load_snap) begin
            car_x_q[0] <= i_Car_X_0;
            car_x_q[1] <= i_Car_X_1;
            car_x_q[2] <= i_Car_X_2;
            car_x_q[3] <= i_Car_X_3;
            car_x_q[4] <= i_Car_X_4;
            car_x_q[5] <= i_Car_X_5;
            frog_x_q   <= i_Frog_X;
            frog_row_q <= i_Frog_Row;
        end
    end

    assign o_Busy      = busy_q;
    assign o_Collision = collision_q;
    assign o_Hit_Index = out_idx_q;
    assign o_Lives     = lives_q;
    assign o_Game_Over = (lives_q == 2'd0);

endmodule

// File: doc/collision_detector.md
COLLISION_DETECTOR -- requirements
Module: collision_detector

Interface
REQ-001 SHALL have parameter TILE_SIZE, default 32, car/frog square size in pixels.
REQ-002 SHALL have parameters CAR_ROW_0..CAR_ROW_5, defaults 1,2,3,4,6,7, the fixed tile row of cars 0..5.
REQ-003 SHALL have parameter C_START_LIVES, default 3, the lives loaded at reset and on restart.
REQ-004 SHALL have parameter C_HIT_COOLDOWN, default 60, the number of accepted frame ticks during which hits are ignored after a hit.
REQ-005 SHALL have port i_Clk, input, 1 bit, the single system clock.
REQ-006 SHALL have port i_Rst_L, input, 1 bit, asynchronous active-low reset.
REQ-007 SHALL have port i_Frame_Tick, input, 1 bit, a one-cycle pulse that requests one scan.
REQ-008 SHALL have port i_Restart, input, 1 bit, a synchronous pulse that reloads lives and clears cooldown.
REQ-009 SHALL have ports i_Car_X_0..i_Car_X_5, input, 10 bits each, the car left-edge X in pixels.
REQ-010 SHALL have port i_Frog_X, input, 10 bits, the frog left-edge X in pixels.
REQ-011 SHALL have port i_Frog_Row, input, 4 bits, the frog tile row.
REQ-012 SHALL have port o_Busy, output, 1 bit, high while the scan is not in IDLE.
REQ-013 SHALL have port o_Collision, output, 1 bit, a one-cycle pulse when a hit is counted.
REQ-014 SHALL have port o_Hit_Index, output, 3 bits, the lowest-numbered car hit in the last counted hit.
REQ-015 SHALL have port o_Lives, output, 2 bits, the remaining lives.
REQ-016 SHALL have port o_Game_Over, output, 1 bit, high while o_Lives is 0.

Function
REQ-017 SHALL implement the states IDLE, SCAN and REPORT.
REQ-018 SHALL, in IDLE with i_Frame_Tick=1 at edge N, snapshot all six car X values, i_Frog_X and i_Frog_Row, clear the hit flag, set the index to 0 and enter SCAN.
REQ-019 SHALL, in SCAN, evaluate one car per cycle using only the snapshotted values, at edges N+1..N+6 for indices 0..5, then enter REPORT.
REQ-020 SHALL define a hit on car i as CAR_ROW_i == frog row AND car_x < frog_x + TILE_SIZE AND frog_x < car_x + TILE_SIZE, with the sums computed 11 bits wide and no screen wrap-around.
REQ-021 SHALL record the index of the first hit found and ignore later hits for the index in the same scan.
REQ-022 SHALL treat a pixel gap of 0 as a hit only when the squares overlap; car_x == frog_x + TILE_SIZE is not a hit.
REQ-023 SHALL, in REPORT at edge N+7, count the hit if the hit flag is 1, the cooldown is 0 and lives > 0, then return to IDLE.
REQ-024 SHALL, on a counted hit, pulse o_Collision high for exactly one cycle after edge N+7, update o_Hit_Index, decrement o_Lives and load the cooldown with C_HIT_COOLDOWN.
REQ-025 SHALL, on REPORT with no counted hit and cooldown > 0, decrement the cooldown by 1.
REQ-026 SHALL saturate o_Lives at 0 and never wrap it.
REQ-027 SHALL ignore i_Frame_Tick while not in IDLE, with no queuing.
REQ-028 SHALL assert o_Busy from after edge N until after edge N+7, giving 7 cycles per scan.
REQ-029 SHALL, on i_Restart, set o_Lives to C_START_LIVES, clear the cooldown and force IDLE, taking priority over the tick and over REPORT in the same cycle.
REQ-030 SHALL allow input changes during SCAN without affecting the result.

Reset
REQ-031 SHALL, while i_Rst_L=0, immediately force state IDLE, o_Busy=0, o_Collision=0, o_Hit_Index=0, o_Lives=C_START_LIVES, o_Game_Over=0 and cooldown=0.
REQ-032 SHALL abandon any scan in progress when reset is asserted mid-scan, without counting a hit.
REQ-033 SHALL accept the first i_Frame_Tick on the first rising edge after reset is released.

Verification
REQ-034 SHALL cover: Frog row 3 X=100, car 2 X=120, tick -> o_Collision pulse at cycle N+7, o_Hit_Index=2, o_Lives 3->2.
REQ-035 SHALL cover: Frog X=100, car 2 X=132 (edge-touching) -> no pulse, o_Lives unchanged.
REQ-036 SHALL cover: Cars 4 and 5 overlapping frog row 6, only car 4 in row 6 -> o_Hit_Index=4; then make cars 0 and 1 both overlap under rows overridden equal -> o_Hit_Index=0.
REQ-037 SHALL cover: A hit followed by 60 ticks of persistent overlap -> no further pulses; tick 61 -> pulse, o_Lives=1.
REQ-038 SHALL cover: Three counted hits -> o_Lives=0, o_Game_Over=1, further hits give no pulse; i_Restart -> o_Lives=3, o_Game_Over=0.
REQ-039 SHALL cover: Reset asserted at cycle N+3 of a hitting scan -> no pulse, o_Lives=3, o_Busy=0; tick during o_Busy -> ignored, next scan starts only from IDLE.
